uart_frame_sender: RTL and testbench
====================================

# uart_frame_sender

Parametrised framed byte sender for the UART TX path. It snapshots `NUM_CH` channel bytes (game state, target, operation, script data, …) at frame start and sends them in order, with an optional header byte and an optional checksum byte. Each byte is handed to the UART transmitter over a valid/ready handshake. Optional zero substitution keeps the link free of 0x00 bytes.

## Interface
- `NUM_CH`, 3, number of channel bytes per frame; legal range 1..16.
- `ZERO_SUB`, 1, when 1 any outgoing byte equal to 8'h00 is replaced by 8'h01.
- `SEND_HEADER`, 0, when 1 every frame begins with `HEADER_BYTE`.
- `HEADER_BYTE`, 8'hAA, header value; zero substitution applies to it as well.
- `SEND_CHECKSUM`, 0, when 1 every frame ends with one checksum byte.

- `uart_clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `enable`  in  1  frame request; sampled only in IDLE.
- `ch_data`  in  8*NUM_CH  channel bytes; channel i is `ch_data[8i+7:8i]`; channel 0 is sent first.
- `tx_ready`  in  1  UART TX can accept a byte this cycle.
- `tx_data`  out  8  byte offered to UART.
- `tx_valid`  out  1  `tx_data` is valid.
- `busy`  out  1  frame in progress (state ≠ IDLE).
- `frame_done`  out  1  one-cycle pulse after the last byte of a frame is accepted.
- `led`  out  8  debug: `{busy, 3'b0, byte_idx[3:0]}`.

## Operation
- States: IDLE, HEADER, DATA, CHECK.
- **IDLE with `enable`=1:**
  - Capture all of `ch_data` into a shadow register.
  - Clear the checksum accumulator and set `byte_idx`=0.
  - Go to HEADER if `SEND_HEADER`=1, else DATA.
- **Frame coherence:** later changes on `ch_data` do not affect the frame in flight.
- **Accept:** `tx_valid`=1 and `tx_ready`=1 in the same cycle. Without an accept, `tx_valid` stays 1 and `tx_data` holds its value (stall of any length).
- **HEADER:** offers `sub(HEADER_BYTE)`. On accept → DATA.
- **DATA:** offers `sub(shadow[byte_idx])`.
  - On accept: `byte_idx`+1, and the accumulator adds the offered, post-substitution byte.
  - After accepting index `NUM_CH`-1 → CHECK if `SEND_CHECKSUM`=1, else IDLE.
- **CHECK:** offers `sub(acc)`, where `acc` is the mod-256 sum of the data bytes as sent. The header is excluded. On accept → IDLE.
- **`sub(x)`:** returns 8'h01 if `ZERO_SUB`=1 and `x`=8'h00; otherwise returns `x`.
- **Frame length:** `SEND_HEADER` + `NUM_CH` + `SEND_CHECKSUM` bytes.
- **Enable deasserted mid-frame:** the frame still completes; frames are atomic.
- **Enable held high:** frames repeat continuously.
- **Reset (`rst_n` low), any time including mid-frame:**
  - State IDLE, `tx_valid`=0, `tx_data`=8'h00, `busy`=0, `frame_done`=0.
  - `byte_idx`=0, accumulator 0, shadow 0, `led`=8'h00.
  - The partial frame is discarded and not resumed.

## Timing
- **Start latency:** `enable` sampled high in IDLE at edge k → `tx_valid`=1 with the first byte from edge k+1.
- **Back-to-back bytes:** accept at edge k → the next byte is on `tx_data` from edge k+1, with `tx_valid` remaining 1. No bubble inside a frame.
- **End of frame:** last byte accepted at edge k → from edge k+1: IDLE, `tx_valid`=0, `frame_done`=1 for exactly one cycle.
  - With `enable`=1, the next frame's first byte is valid from edge k+2.
  - Minimum inter-frame gap is therefore one cycle.
- **Ready dependency:** `tx_valid` never depends combinationally on `tx_ready`; all outputs are registered.
- **Stall:** `tx_ready` held low for N cycles extends the frame by N cycles; no byte is dropped or duplicated.
- **Throughput:** with `tx_ready` tied high, one frame takes L+1 cycles.

## Test plan
- **Defaults, basic frame.** `NUM_CH`=3, `ch_data`={8'h00,8'h22,8'h11}, `tx_ready`=1, one `enable` pulse → accepted bytes 8'h11, 8'h22, 8'h01; `frame_done` pulses one cycle after the third accept; then idle.
- **Header and checksum.** `SEND_HEADER`=1, `SEND_CHECKSUM`=1, same data → 8'hAA, 8'h11, 8'h22, 8'h01, 8'h34.
- **Checksum wraps to zero.** `NUM_CH`=2, `SEND_CHECKSUM`=1, data 8'h80, 8'h80 → bytes 8'h80, 8'h80, 8'h01 (sum 8'h00, substituted). Repeat with `ZERO_SUB`=0 → 8'h80, 8'h80, 8'h00.
- **Stall and snapshot.** `tx_ready` low for 5 cycles during byte 1, and `ch_data` changed to all 8'hFF mid-frame → byte 1 held stable for the whole stall; all bytes come from the snapshot; the next frame sends 8'hFF ×3.
- **Continuous and atomic frames.** `enable` held high for 3 frames → exactly one `tx_valid`-low cycle between frames. Separately, `enable` dropped after the first accept → the frame still completes.
- **Reset mid-frame.** `rst_n` low while in DATA at `byte_idx`=1 → outputs go to reset values immediately (asynchronously). After release with `enable`=1, a fresh frame starts from channel 0.

Source files
------------

// File: rtl/uart_frame_sender.sv
// Framed byte sender for the UART TX path: snapshots NUM_CH channel bytes and emits
// [header] ch0..chN-1 [checksum] over a valid/ready handshake with registered outputs.
module uart_frame_sender #(
  parameter int         NUM_CH        = 3,
  parameter bit         ZERO_SUB      = 1'b1,
  parameter bit         SEND_HEADER   = 1'b0,
  parameter logic [7:0] HEADER_BYTE   = 8'hAA,
  parameter bit         SEND_CHECKSUM = 1'b0
) (
  input  logic                  uart_clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic [8*NUM_CH-1:0]   ch_data,
  input  logic                  tx_ready,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  output logic                  busy,
  output logic                  frame_done,
  output logic [7:0]            led
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HEADER,
    S_DATA,
    S_CHECK
  } state_e;

  // Five bits so the index can step past 15 when NUM_CH is 16.
  localparam int IDX_W = 5;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CH - 1);

  state_e               state_q,  state_d;
  logic [8*NUM_CH-1:0]  shadow_q, shadow_d;
  logic [IDX_W-1:0]     idx_q,    idx_d;
  logic [7:0]           acc_q,    acc_d;
  logic [7:0]           data_q,   data_d;
  logic                 valid_q,  valid_d;
  logic                 done_q,   done_d;

  logic                 accept;
  logic [7:0]           acc_next;

  function automatic logic [7:0] sub(input logic [7:0] x);
    sub = (ZERO_SUB && (x == 8'h00)) ? 8'h01 : x;
  endfunction

  function automatic logic [7:0] pick(input logic [8*NUM_CH-1:0] sh,
                                      input logic [IDX_W-1:0]   idx);
    pick = 8'h00;
    for (int i = 0; i < NUM_CH; i++) begin
      if (idx == IDX_W'(i)) pick = sh[8*i +: 8];
    end
  endfunction

  assign accept   = valid_q & tx_ready;
  // The offered byte is already substituted, so the sum covers bytes as sent.
  assign acc_next = acc_q + data_q;

  // The next byte is computed here and registered, so tx_data is ready the cycle
  // after an accept without any combinational path from tx_ready to the outputs.
  always_comb begin
    // NOTE: every variable gets a default before the case so no latch is inferred.
    state_d  = state_q;
    shadow_d = shadow_q;
    idx_d    = idx_q;
    acc_d    = acc_q;
    data_d   = data_q;
    valid_d  = valid_q;
    done_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (enable) begin
          shadow_d = ch_data;
          idx_d    = '0;
          acc_d    = 8'h00;
          valid_d  = 1'b1;
          if (SEND_HEADER) begin
            state_d = S_HEADER;
            data_d  = sub(HEADER_BYTE);
          end else begin
            state_d = S_DATA;
            data_d  = sub(ch_data[7:0]);
          end
        end
      end

      S_HEADER: begin
        if (accept) begin
          state_d = S_DATA;
          data_d  = sub(pick(shadow_q, '0));
        end
      end

      S_DATA: begin
        if (accept) begin
          acc_d = acc_next;
          idx_d = idx_q + 5'd1;
          if (idx_q == LAST_IDX) begin
            if (SEND_CHECKSUM) begin
              state_d = S_CHECK;
              data_d  = sub(acc_next);
            end else begin
              state_d = S_IDLE;
              valid_d = 1'b0;
              done_d  = 1'b1;
            end
          end else begin
            data_d = sub(pick(shadow_q, idx_q + 5'd1));
          end
        end
      end

      S_CHECK: begin
        if (accept) begin
          state_d = S_IDLE;
          valid_d = 1'b0;
          done_d  = 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge uart_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      // NOTE: the shadow is plain flops rather than a RAM, so it takes the async reset too.
      shadow_q <= '0;
      idx_q    <= '0;
      acc_q    <= 8'h00;
      data_q   <= 8'h00;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register updates from the same pre-edge values.
      state_q  <= state_d;
      shadow_q <= shadow_d;
      idx_q    <= idx_d;
      acc_q    <= acc_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      done_q   <= done_d;
    end
  end

  assign tx_data    = data_q;
  assign tx_valid   = valid_q;
  assign busy       = (state_q != S_IDLE);
  assign frame_done = done_q;
  assign led        = {busy, 3'b000, idx_q[3:0]};

endmodule

// File: tb/tb_uart_frame_sender.sv
// Scoreboard bench for uart_frame_sender: three parameterisations share clock, reset
// and tx_ready; stimulus pushes hand-computed bytes, a negedge monitor pops and checks.
module tb_uart_frame_sender;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } exp_t;

  logic            clk;
  logic            rst_n;
  logic            ready;
  logic [2:0]      en;
  logic [23:0]     data_a;
  logic [15:0]     data_b;
  logic [23:0]     data_c;
  logic [2:0][7:0] txd;
  logic [2:0]      vld;
  logic [2:0]      bsy;
  logic [2:0]      fd;
  logic [2:0][7:0] leds;

  exp_t       q [3][$];
  logic [2:0] prev_last;
  logic [2:0] prev_mid;
  logic [2:0] prev_stall;
  logic [7:0] prev_data [3];

  int n_checks = 0;
  int n_errors = 0;

  // A: header + checksum + zero substitution
  uart_frame_sender #(.NUM_CH(3), .ZERO_SUB(1'b1), .SEND_HEADER(1'b1),
                      .HEADER_BYTE(8'hAA), .SEND_CHECKSUM(1'b1)) dut_a (
    .uart_clk(clk), .rst_n(rst_n), .enable(en[0]), .ch_data(data_a), .tx_ready(ready),
    .tx_data(txd[0]), .tx_valid(vld[0]), .busy(bsy[0]), .frame_done(fd[0]), .led(leds[0]));

  // B: two channels, checksum, no substitution
  uart_frame_sender #(.NUM_CH(2), .ZERO_SUB(1'b0), .SEND_HEADER(1'b0),
                      .HEADER_BYTE(8'hAA), .SEND_CHECKSUM(1'b1)) dut_b (
    .uart_clk(clk), .rst_n(rst_n), .enable(en[1]), .ch_data(data_b), .tx_ready(ready),
    .tx_data(txd[1]), .tx_valid(vld[1]), .busy(bsy[1]), .frame_done(fd[1]), .led(leds[1]));

  // C: defaults
  uart_frame_sender #(.NUM_CH(3), .ZERO_SUB(1'b1), .SEND_HEADER(1'b0),
                      .HEADER_BYTE(8'hAA), .SEND_CHECKSUM(1'b0)) dut_c (
    .uart_clk(clk), .rst_n(rst_n), .enable(en[2]), .ch_data(data_c), .tx_ready(ready),
    .tx_data(txd[2]), .tx_valid(vld[2]), .busy(bsy[2]), .frame_done(fd[2]), .led(leds[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic mon(input int id);
    exp_t e;
    if (!rst_n) begin
      prev_last[id]  = 1'b0;
      prev_mid[id]   = 1'b0;
      prev_stall[id] = 1'b0;
      return;
    end
    check($sformatf("frame_done[%0d]", id), 32'(fd[id]), 32'(prev_last[id]));
    if (prev_last[id])  check($sformatf("gap_valid_low[%0d]", id), 32'(vld[id]), 32'd0);
    if (prev_mid[id])   check($sformatf("no_bubble[%0d]", id), 32'(vld[id]), 32'd1);
    if (prev_stall[id]) begin
      check($sformatf("stall_valid[%0d]", id), 32'(vld[id]), 32'd1);
      check($sformatf("stall_hold[%0d]", id), 32'(txd[id]), 32'(prev_data[id]));
    end
    prev_last[id] = 1'b0;
    prev_mid[id]  = 1'b0;
    if (vld[id] && ready) begin
      if (q[id].size() == 0) begin
        check($sformatf("unexpected_byte[%0d]", id), 32'(txd[id]), 32'hFFFF_FFFF);
      end else begin
        e = q[id].pop_front();
        check($sformatf("byte[%0d]", id), 32'(txd[id]), 32'(e.data));
        prev_last[id] = e.last;
        prev_mid[id]  = ~e.last;
      end
    end
    prev_stall[id] = vld[id] & ~ready;
    prev_data[id]  = txd[id];
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) mon(i);
  end

  task automatic push(input int id, input logic [7:0] b, input logic last);
    exp_t e;
    e.data = b;
    e.last = last;
    q[id].push_back(e);
  endtask

  task automatic start(input int id);
    en[id] = 1'b1;
    @(posedge clk); #1;
    check($sformatf("start_latency[%0d]", id), 32'(vld[id]), 32'd1);
    en[id] = 1'b0;
  endtask

  task automatic drain(input int id);
    int n;
    n = 0;
    while (q[id].size() != 0 && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    check($sformatf("drain[%0d]", id), 32'(q[id].size()), 32'd0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n  = 1'b0;
    ready  = 1'b1;
    en     = 3'b000;
    data_a = 24'h0;
    data_b = 16'h0;
    data_c = 24'h0;
    prev_last = '0; prev_mid = '0; prev_stall = '0;
    #1;
    check("rst_valid", 32'(vld), 32'd0);
    check("rst_data_a", 32'(txd[0]), 32'd0);
    check("rst_busy", 32'(bsy), 32'd0);
    check("rst_led_a", 32'(leds[0]), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic frame, defaults: channel 2 = 00 becomes 01
    data_c = {8'h00, 8'h22, 8'h11};
    push(2, 8'h11, 1'b0); push(2, 8'h22, 1'b0); push(2, 8'h01, 1'b1);
    start(2);
    drain(2);
    check("idle_after_frame_c", 32'(bsy[2]), 32'd0);

    // Header and checksum: 11+22+01 = 34
    data_a = {8'h00, 8'h22, 8'h11};
    push(0, 8'hAA, 1'b0); push(0, 8'h11, 1'b0); push(0, 8'h22, 1'b0);
    push(0, 8'h01, 1'b0); push(0, 8'h34, 1'b1);
    start(0);
    drain(0);

    // Checksum wraps to zero with substitution: 80+7F+01 = 100 -> 00 -> 01
    data_a = {8'h01, 8'h7F, 8'h80};
    push(0, 8'hAA, 1'b0); push(0, 8'h80, 1'b0); push(0, 8'h7F, 1'b0);
    push(0, 8'h01, 1'b0); push(0, 8'h01, 1'b1);
    start(0);
    drain(0);

    // No substitution: 80+80 = 00 is sent as 00
    data_b = {8'h80, 8'h80};
    push(1, 8'h80, 1'b0); push(1, 8'h80, 1'b0); push(1, 8'h00, 1'b1);
    start(1);
    drain(1);
    data_b = {8'h00, 8'h05};
    push(1, 8'h05, 1'b0); push(1, 8'h00, 1'b0); push(1, 8'h05, 1'b1);
    start(1);
    drain(1);

    // Stall on byte 1 for 5 cycles while ch_data changes: 11+22+33 = 66
    data_a = {8'h33, 8'h22, 8'h11};
    push(0, 8'hAA, 1'b0); push(0, 8'h11, 1'b0); push(0, 8'h22, 1'b0);
    push(0, 8'h33, 1'b0); push(0, 8'h66, 1'b1);
    start(0);
    @(posedge clk); #1;
    ready  = 1'b0;
    data_a = 24'hFFFFFF;
    repeat (5) @(posedge clk);
    #1;
    check("stall_byte1", 32'(txd[0]), 32'h11);
    ready = 1'b1;
    drain(0);
    // Next frame uses the new data: FF*3 = 2FD -> FD
    push(0, 8'hAA, 1'b0); push(0, 8'hFF, 1'b0); push(0, 8'hFF, 1'b0);
    push(0, 8'hFF, 1'b0); push(0, 8'hFD, 1'b1);
    start(0);
    drain(0);

    // Continuous: frames start at edges 1, 5, 9; last frame_done appears after edge 12
    data_c = {8'h03, 8'h02, 8'h01};
    for (int f = 0; f < 3; f++) begin
      push(2, 8'h01, 1'b0); push(2, 8'h02, 1'b0); push(2, 8'h03, 1'b1);
    end
    en[2] = 1'b1;
    repeat (9) @(posedge clk);
    #1 en[2] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("cont_done_time", 32'(fd[2]), 32'd1);
    check("cont_drained", 32'(q[2].size()), 32'd0);
    drain(2);

    // Atomic: enable dropped mid-frame, frame still completes
    data_c = {8'h0C, 8'h0B, 8'h0A};
    push(2, 8'h0A, 1'b0); push(2, 8'h0B, 1'b0); push(2, 8'h0C, 1'b1);
    en[2] = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    en[2] = 1'b0;
    drain(2);

    // Reset mid-frame in DATA at byte_idx 1
    data_a = {8'h66, 8'h55, 8'h44};
    push(0, 8'hAA, 1'b0); push(0, 8'h44, 1'b0); push(0, 8'h55, 1'b0);
    push(0, 8'h66, 1'b0); push(0, 8'hFF, 1'b1);
    start(0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("pre_rst_data", 32'(txd[0]), 32'h55);
    check("pre_rst_led", 32'(leds[0]), 32'h81);
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) q[i].delete();
    #1;
    check("mid_rst_valid", 32'(vld[0]), 32'd0);
    check("mid_rst_data", 32'(txd[0]), 32'd0);
    check("mid_rst_busy", 32'(bsy[0]), 32'd0);
    check("mid_rst_done", 32'(fd[0]), 32'd0);
    check("mid_rst_led", 32'(leds[0]), 32'd0);
    // Fresh frame from channel 0: 44+55+66 = FF
    push(0, 8'hAA, 1'b0); push(0, 8'h44, 1'b0); push(0, 8'h55, 1'b0);
    push(0, 8'h66, 1'b0); push(0, 8'hFF, 1'b1);
    en[0] = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_start", 32'(vld[0]), 32'd1);
    en[0] = 1'b0;
    drain(0);

    for (int i = 0; i < 3; i++) check($sformatf("queue_empty[%0d]", i), 32'(q[i].size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
